// File: rtl/rect_capture_ctrl.sv
// rect_capture_ctrl: captures two pen corners on button presses. It previews
// and displays the rectangle with frame-synchronous updates, then commits a
// normalized rectangle {x_min, y_min, x_max, y_max} over a valid/ready
// handshake.
// Optional feature macro: RECT_PREVIEW_EN. When it is defined, the display
// tracks the live corners while in CORNER2.
module rect_capture_ctrl #(
  parameter int MIN_SIZE       = 8,
  parameter int V_ACTIVE       = 720,
  parameter int TIMEOUT_FRAMES = 60
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_in,
  input  logic        point_valid_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [10:0] x_out_1,
  output logic [10:0] x_out_2,
  output logic [9:0]  y_out_1,
  output logic [9:0]  y_out_2,
  output logic        rect_valid_out,
  input  logic        rect_ready_in,
  output logic [41:0] rect_out,
  output logic        reject_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORNER1 = 2'd1,
    CORNER2 = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t      state, state_d;
  logic        btn_prev;
  logic        have_pt;
  logic [7:0]  tcnt;
  logic [10:0] p1_x, p2_x;
  logic [9:0]  p1_y, p2_y;
  logic [41:0] committed;
  logic [41:0] disp_src;

  // Control strobes produced by the FSM.
  logic enter_c1, load_pt1, load_pt2, do_commit, do_reject;

  logic rise, frame_edge, timeout_hit, handshake;
  assign rise        = btn_in & ~btn_prev;
  assign frame_edge  = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));
  // The >= comparison means a saturated counter still times out at the next
  // frame boundary. This covers the case where a rise beat a timeout.
  assign timeout_hit = frame_edge && !point_valid_in &&
                       (tcnt >= 8'(TIMEOUT_FRAMES - 1));
  assign handshake   = rect_valid_out & rect_ready_in;

  // A point arriving with the commit press is used directly (bypass).
  logic [10:0] c2_x, x_min, x_max;
  logic [9:0]  c2_y, y_min, y_max;
  logic        size_ok;
  assign c2_x    = point_valid_in ? x_in : p2_x;
  assign c2_y    = point_valid_in ? y_in : p2_y;
  assign x_min   = (p1_x < c2_x) ? p1_x : c2_x;
  assign x_max   = (p1_x < c2_x) ? c2_x : p1_x;
  assign y_min   = (p1_y < c2_y) ? p1_y : c2_y;
  assign y_max   = (p1_y < c2_y) ? c2_y : p1_y;
  // max - min never wraps, so an unsigned compare is safe.
  assign size_ok = ((x_max - x_min) >= 11'(MIN_SIZE)) &&
                   ((y_max - y_min) >= 10'(MIN_SIZE));

`ifdef RECT_PREVIEW_EN
  // The preview uses the registered corners, normalized the same way.
  logic [10:0] pv_x_min, pv_x_max;
  logic [9:0]  pv_y_min, pv_y_max;
  assign pv_x_min = (p1_x < p2_x) ? p1_x : p2_x;
  assign pv_x_max = (p1_x < p2_x) ? p2_x : p1_x;
  assign pv_y_min = (p1_y < p2_y) ? p1_y : p2_y;
  assign pv_y_max = (p1_y < p2_y) ? p2_y : p1_y;
  assign disp_src = (state == CORNER2) ? {pv_x_min, pv_y_min, pv_x_max, pv_y_max}
                                       : committed;
`else
  assign disp_src = committed;
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: every flop, including the wide data registers, resets
    // synchronously. The display must show a zero-width rectangle immediately.
    if (rst_in) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update from the same pre-edge values.
    else        state <= state_d;
  end

  // Next-state and control-strobe decode.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d   = state;
    enter_c1  = 1'b0;
    load_pt1  = 1'b0;
    load_pt2  = 1'b0;
    do_commit = 1'b0;
    do_reject = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d  = CORNER1;
          enter_c1 = 1'b1;
        end
      end
      CORNER1: begin
        load_pt1 = point_valid_in;
        if (rise && have_pt) state_d = CORNER2;
        else if (timeout_hit) state_d = IDLE;
      end
      CORNER2: begin
        load_pt2 = point_valid_in;
        if (rise) begin
          if (size_ok) begin
            do_commit = 1'b1;
            state_d   = COMMIT;
          end else begin
            do_reject = 1'b1;
            enter_c1  = 1'b1;
            state_d   = CORNER1;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      COMMIT: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Button history, corners, have-point flag and frame timeout counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      btn_prev <= 1'b0;
      have_pt  <= 1'b0;
      tcnt     <= 8'd0;
      p1_x     <= 11'd0;
      p1_y     <= 10'd0;
      p2_x     <= 11'd0;
      p2_y     <= 10'd0;
    end else begin
      btn_prev <= btn_in;
      if (enter_c1)      have_pt <= 1'b0;
      else if (load_pt1) have_pt <= 1'b1;
      if (enter_c1 || point_valid_in)
        tcnt <= 8'd0;
      else if (frame_edge && (state == CORNER1 || state == CORNER2) && tcnt != 8'hFF)
        tcnt <= tcnt + 8'd1;
      if (load_pt1) begin
        p1_x <= x_in;
        p1_y <= y_in;
      end
      if (load_pt1 || load_pt2) begin
        p2_x <= x_in;
        p2_y <= y_in;
      end
    end
  end

  // Commit output, handshake and committed-rectangle register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rect_out       <= 42'd0;
      rect_valid_out <= 1'b0;
      reject_out     <= 1'b0;
      committed      <= 42'd0;
    end else begin
      reject_out <= do_reject;
      if (do_commit) begin
        rect_out       <= {x_min, y_min, x_max, y_max};
        rect_valid_out <= 1'b1;
      end else if (handshake) begin
        rect_valid_out <= 1'b0;
        committed      <= rect_out;
      end
    end
  end

  // Display corners change only at the frame boundary.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_out_1 <= 11'd0;
      y_out_1 <= 10'd0;
      x_out_2 <= 11'd0;
      y_out_2 <= 10'd0;
    end else if (frame_edge) begin
      {x_out_1, y_out_1, x_out_2, y_out_2} <= disp_src;
    end
  end

  assign state_out = state;

endmodule
